// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding,
// per-field moduli and field-select codes.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    localparam logic [1:0] SEL_MSEC = 2'b00;
    localparam logic [1:0] SEL_SEC  = 2'b01;
    localparam logic [1:0] SEL_MIN  = 2'b10;
    localparam logic [1:0] SEL_HOUR = 2'b11;

endpackage

// File: rtl/tick_down_counter.sv
// One time field: wrapping inc/dec for presetting, plus borrow-driven decrement
// so instances chain from centiseconds up to hours.
module tick_down_counter #(
    parameter int MOD   = 100,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_borrow_in,
    output logic [WIDTH-1:0] o_value,
    output logic             o_borrow_out
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_value;
    logic             w_at_zero;

    assign w_at_zero    = (r_value == '0);
    assign o_borrow_out = i_borrow_in && w_at_zero;
    assign o_value      = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= (r_value == MAX_VAL) ? '0 : r_value + WIDTH'(1);
        end else if (i_dec || i_borrow_in) begin
            r_value <= w_at_zero ? MAX_VAL : r_value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_core.sv
// Countdown timer: 100 Hz prescaler, run/pause/done FSM and the HH:MM:SS.CC
// field chain that feeds the display bus.
module countdown_timer_core
    import timer_pkg::*;
#(
    parameter int FCOUNT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [1:0] sel,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       o_running,
    output logic       o_done,
    output logic       o_alarm
);

    localparam int PW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(FCOUNT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_done;
    logic          r_alarm;
    logic          w_running_nxt;
    logic          w_done_nxt;
    logic          w_alarm_nxt;

    logic          w_tick;
    logic          w_borrow;
    logic          w_clear_fields;
    logic          w_inc;
    logic          w_dec;
    logic          w_time_zero;
    logic          w_last_tick;
    logic          w_msec_borrow;
    logic          w_sec_borrow;
    logic          w_min_borrow;
    logic          w_hour_borrow;

    assign w_tick         = (r_state == RUN) && (r_presc == PRESC_MAX);
    assign w_borrow       = w_tick && !btn_clear;
    assign w_clear_fields = btn_clear;
    assign w_inc          = (r_state == IDLE) && !btn_clear && !btn_run && btn_up;
    assign w_dec          = (r_state == IDLE) && !btn_clear && !btn_run && btn_down;
    assign w_time_zero    = (msec == '0) && (sec == '0) && (min == '0) && (hour == '0);
    // The tick that takes 00:00:00.01 to zero; an hour borrow can never happen but would also end the run.
    assign w_last_tick    = w_tick && (((msec == 7'd1) && (sec == '0) && (min == '0) && (hour == '0))
                                       || w_hour_borrow);

    tick_down_counter #(.MOD(MSEC_MOD), .WIDTH(7)) u_msec (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (w_clear_fields),
        .i_inc       (w_inc && (sel == SEL_MSEC)),
        .i_dec       (w_dec && (sel == SEL_MSEC)),
        .i_borrow_in (w_borrow),
        .o_value     (msec),
        .o_borrow_out(w_msec_borrow)
    );

    tick_down_counter #(.MOD(SEC_MOD), .WIDTH(6)) u_sec (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (w_clear_fields),
        .i_inc       (w_inc && (sel == SEL_SEC)),
        .i_dec       (w_dec && (sel == SEL_SEC)),
        .i_borrow_in (w_msec_borrow),
        .o_value     (sec),
        .o_borrow_out(w_sec_borrow)
    );

    tick_down_counter #(.MOD(MIN_MOD), .WIDTH(6)) u_min (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (w_clear_fields),
        .i_inc       (w_inc && (sel == SEL_MIN)),
        .i_dec       (w_dec && (sel == SEL_MIN)),
        .i_borrow_in (w_sec_borrow),
        .o_value     (min),
        .o_borrow_out(w_min_borrow)
    );

    tick_down_counter #(.MOD(HOUR_MOD), .WIDTH(5)) u_hour (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (w_clear_fields),
        .i_inc       (w_inc && (sel == SEL_HOUR)),
        .i_dec       (w_dec && (sel == SEL_HOUR)),
        .i_borrow_in (w_min_borrow),
        .o_value     (hour),
        .o_borrow_out(w_hour_borrow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (!btn_clear && btn_run && !w_time_zero) w_state_nxt = RUN;
            end
            RUN: begin
                if (btn_clear)        w_state_nxt = IDLE;
                else if (w_last_tick) w_state_nxt = DONE;
                else if (btn_run)     w_state_nxt = PAUSE;
            end
            PAUSE: begin
                if (btn_clear)    w_state_nxt = IDLE;
                else if (btn_run) w_state_nxt = RUN;
            end
            DONE: begin
                if (btn_clear || btn_run) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_running_nxt = (w_state_nxt == RUN);
        w_alarm_nxt   = (w_state_nxt == DONE);
        w_done_nxt    = (r_state == RUN) && !btn_clear && w_last_tick;
    end

    // Prescaler zeroes on entering IDLE and on IDLE->RUN so the first tick lands FCOUNT cycles after run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if ((r_state == IDLE) || (w_state_nxt == IDLE)) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_running <= w_running_nxt;
            r_done    <= w_done_nxt;
            r_alarm   <= w_alarm_nxt;
        end
    end

    assign o_running = r_running;
    assign o_done    = r_done;
    assign o_alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed bench for countdown_timer_core with a 4-cycle prescaler.
module tb_countdown_timer_core;

    logic       clk;
    logic       reset;
    logic       btn_run;
    logic       btn_clear;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] sel;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       o_running;
    logic       o_done;
    logic       o_alarm;

    int errors = 0;
    int checks = 0;

    countdown_timer_core #(.FCOUNT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_clear(btn_clear),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .sel      (sel),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .o_running(o_running),
        .o_done   (o_done),
        .o_alarm  (o_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buttons are raised at a negedge, sampled on the next posedge, dropped at the following negedge.
    task automatic press(input bit run, input bit clr, input bit up, input bit dn);
        btn_run   = run;
        btn_clear = clr;
        btn_up    = up;
        btn_down  = dn;
        @(negedge clk);
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({hour, min, sec, msec} !== 24'd0) begin
            errors++;
            $display("FAIL reset_time: got %0d:%0d:%0d.%0d want 0:0:0.0", hour, min, sec, msec);
        end
        checks++;
        if ({o_running, o_done, o_alarm} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got run/done/alarm=%b want 000", {o_running, o_done, o_alarm});
        end
    endtask

    task automatic test_full_countdown;
        int done_cnt = 0;
        int done_at  = -1;
        sel = 2'b01;
        press(0, 0, 1, 0);
        checks++;
        if (sec !== 6'd1) begin
            errors++;
            $display("FAIL preset_sec: got %0d want 1", sec);
        end
        press(1, 0, 0, 0);
        checks++;
        if (o_running !== 1'b1) begin
            errors++;
            $display("FAIL run_start: got o_running=%b want 1", o_running);
        end
        for (int i = 1; i <= 450; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 400) begin
            errors++;
            $display("FAIL done_pulse: got count=%0d at=%0d want count=1 at=400", done_cnt, done_at);
        end
        checks++;
        if ({o_alarm, o_running} !== 2'b10 || {hour, min, sec, msec} !== 24'd0) begin
            errors++;
            $display("FAIL done_state: got alarm=%b run=%b time=%0d.%0d want alarm=1 run=0 time=0",
                     o_alarm, o_running, sec, msec);
        end
        press(1, 0, 0, 0);
        checks++;
        if ({o_alarm, o_running} !== 2'b00) begin
            errors++;
            $display("FAIL alarm_ack: got alarm=%b run=%b want 0 0", o_alarm, o_running);
        end
    endtask

    task automatic test_borrow_chain;
        sel = 2'b11;
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        wait_cycles(4);
        checks++;
        if (hour !== 5'd0 || min !== 6'd59 || sec !== 6'd59 || msec !== 7'd99 || o_running !== 1'b1) begin
            errors++;
            $display("FAIL borrow_chain: got %0d:%0d:%0d.%0d run=%b want 0:59:59.99 run=1",
                     hour, min, sec, msec, o_running);
        end
        press(0, 1, 0, 0);
        checks++;
        if ({hour, min, sec, msec} !== 24'd0 || o_running !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_run: got %0d:%0d:%0d.%0d run=%b want 0 run=0",
                     hour, min, sec, msec, o_running);
        end
    endtask

    task automatic test_field_wrap;
        sel = 2'b10;
        press(0, 0, 0, 1);
        checks++;
        if (min !== 6'd59) begin
            errors++;
            $display("FAIL min_wrap: got %0d want 59", min);
        end
        sel = 2'b11;
        press(0, 0, 0, 1);
        checks++;
        if (hour !== 5'd23) begin
            errors++;
            $display("FAIL hour_wrap: got %0d want 23", hour);
        end
        sel = 2'b01;
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        sel = 2'b00;
        press(0, 0, 0, 1);
        checks++;
        if (msec !== 7'd99 || sec !== 6'd2) begin
            errors++;
            $display("FAIL msec_down_wrap: got msec=%0d sec=%0d want 99 2", msec, sec);
        end
        press(0, 0, 1, 0);
        checks++;
        if (msec !== 7'd0 || sec !== 6'd2 || min !== 6'd59 || hour !== 5'd23) begin
            errors++;
            $display("FAIL msec_up_wrap: got %0d:%0d:%0d.%0d want 23:59:2.0", hour, min, sec, msec);
        end
        press(0, 1, 0, 0);
    endtask

    task automatic test_pause_hold;
        int changed = 0;
        sel = 2'b01;
        for (int i = 0; i < 5; i++) press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        wait_cycles(39);
        press(1, 0, 0, 0);
        checks++;
        if (sec !== 6'd4 || msec !== 7'd90 || o_running !== 1'b0) begin
            errors++;
            $display("FAIL pause_value: got %0d.%0d run=%b want 4.90 run=0", sec, msec, o_running);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sec !== 6'd4 || msec !== 7'd90 || o_running !== 1'b0) changed++;
        end
        checks++;
        if (changed !== 0) begin
            errors++;
            $display("FAIL pause_hold: got %0d changed cycles want 0", changed);
        end
        press(1, 1, 0, 0);
        wait_cycles(8);
        checks++;
        if ({hour, min, sec, msec} !== 24'd0 || o_running !== 1'b0 || o_alarm !== 1'b0) begin
            errors++;
            $display("FAIL clear_beats_run: got %0d.%0d run=%b alarm=%b want 0 run=0 alarm=0",
                     sec, msec, o_running, o_alarm);
        end
    endtask

    task automatic test_zero_run_and_reset;
        int done_seen = 0;
        press(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_running !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL zero_run: got %0d bad cycles want 0", done_seen);
        end
        sel = 2'b01;
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        wait_cycles(10);
        checks++;
        if (o_running !== 1'b1 || sec !== 6'd0 || msec !== 7'd98) begin
            errors++;
            $display("FAIL pre_reset_run: got run=%b %0d.%0d want run=1 0.98", o_running, sec, msec);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({hour, min, sec, msec} !== 24'd0 || {o_running, o_done, o_alarm} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got time=%0d.%0d flags=%b want 0 000",
                     sec, msec, {o_running, o_done, o_alarm});
        end
        wait_cycles(2);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({o_running, o_done, o_alarm} !== 3'b000 || {sec, msec} !== 13'd0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL post_reset: got %0d bad cycles want 0", done_seen);
        end
    endtask

    initial begin
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        sel       = 2'b00;
        reset     = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_countdown();
        test_borrow_chain();
        test_field_wrap();
        test_pause_hold();
        test_zero_run_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
